uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address and length width.
REQ-002 Parameter DATA_W, default 8, RAM data and UART byte width.
REQ-003 sclk  input  1  system clock; all logic on rising edge.
REQ-004 srst  input  1  synchronous reset, active-high.
REQ-005 req0  input  1  requester 0 start, one-cycle pulse.
REQ-006 base0  input  ADDR_W  requester 0 start address, sampled with req0.
REQ-007 len0  input  ADDR_W  requester 0 byte count, sampled with req0.
REQ-008 req1, base1, len1  input  1/ADDR_W/ADDR_W  same as requester 0, for requester 1.
REQ-009 grant0, grant1  output  1 each  high while that requester's transfer is in service.
REQ-010 done0, done1  output  1 each  one-cycle pulse at end of that requester's transfer.
REQ-011 ram_addr  output  ADDR_W  RAM read address.
REQ-012 ram_rd_en  output  1  RAM read strobe; data valid on ram_rdata one cycle later.
REQ-013 ram_rdata  input  DATA_W  RAM read data.
REQ-014 tx_data  output  DATA_W  byte to UART transmitter, held stable from tx_trig until tx_busy falls.
REQ-015 tx_trig  output  1  one-cycle start pulse to UART transmitter.
REQ-016 tx_busy  input  1  UART transmitter busy.

Function
REQ-017 Each reqN pulse SHALL set pendN and capture baseN/lenN into a per-requester shadow register; a reqN while pendN is set SHALL overwrite the shadow.
REQ-018 States SHALL be IDLE, READ, LATCH, TRIG, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-019 IDLE: if any pend set, select a winner, clear its pend, load ptr=base, cnt=0, len from shadow, assert grantN; go to DONE if len==0, else READ.
REQ-020 Arbitration: only one pending -> that one; both pending -> requester not served last (round robin); last-served resets to 1, so requester 0 wins first.
REQ-021 READ: ram_rd_en=1 and ram_addr=ptr for exactly one cycle -> LATCH.
REQ-022 LATCH: tx_data<=ram_rdata -> TRIG.
REQ-023 TRIG: tx_trig=1 for exactly one cycle -> WAIT_BUSY.
REQ-024 WAIT_BUSY: remain until tx_busy=1 -> WAIT_IDLE; tx_trig SHALL NOT be reasserted.
REQ-025 WAIT_IDLE: remain until tx_busy=0; then cnt+1, ptr+1 (modulo 2^ADDR_W, 255->0 wraps); if cnt+1==len -> DONE else READ.
REQ-026 DONE: doneN=1 for one cycle, grantN cleared on exit, last-served updated -> IDLE.
REQ-027 Byte issue latency from entering READ to tx_trig SHALL be 2 cycles; minimum gap from IDLE winner selection to first tx_trig SHALL be 3 cycles.
REQ-028 reqN arriving during its own transfer SHALL be queued as pending and served after current DONE, subject to REQ-020.
REQ-029 Simultaneous req0 and req1 in IDLE SHALL both pend in that cycle; arbitration applies on the next IDLE cycle.
REQ-030 At most one grant SHALL be high at any time; grant and done of a requester SHALL both be high in the DONE cycle.

Reset
REQ-031 srst=1 SHALL force state IDLE, pend0/pend1=0, last-served=1, ptr/cnt=0, and all outputs (grant0, grant1, done0, done1, ram_addr, ram_rd_en, tx_data, tx_trig) to 0 on the next edge.
REQ-032 srst asserted mid-transfer SHALL abort without emitting done; requests pulsed during srst SHALL be discarded.

Verification
REQ-033 req0, base0=0x10, len0=3, UART model busy 40 cycles per byte -> ram_addr 0x10,0x11,0x12, three tx_trig with matching ram data, one done0, grant0 high throughout.
REQ-034 req0 and req1 same cycle (len 2 each) -> requester 0 served fully first, then requester 1; grants never overlap; done0 precedes done1.
REQ-035 base1=0xFE, len1=4 -> ram_addr 0xFE,0xFF,0x00,0x01.
REQ-036 len0=0 -> no ram_rd_en, no tx_trig, done0 pulse within 2 cycles of req0.
REQ-037 tx_busy held 0 for 20 cycles after tx_trig -> block stays in WAIT_BUSY, no second tx_trig; progresses once tx_busy pulses.
REQ-038 srst asserted after second byte of len0=5 transfer -> all outputs 0 next edge, no done0; new req1 after release served normally from requester 1 base.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// RAM read port and UART transmitter handshake shared by the scheduler and its environment.
// The master side is the scheduler; the slave side is the RAM/UART.
interface uart_tx_sched_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_rd_en;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] tx_data;
    logic              tx_trig;
    logic              tx_busy;

    modport master (
        output ram_addr,
        output ram_rd_en,
        output tx_data,
        output tx_trig,
        input  ram_rdata,
        input  tx_busy
    );

    modport slave (
        input  ram_addr,
        input  ram_rd_en,
        input  tx_data,
        input  tx_trig,
        output ram_rdata,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler that streams bytes from RAM into a UART transmitter.
// Outputs are registered from the next-state decode, so they line up with the state register.
module uart_tx_sched #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              sclk,
    input  logic              srst,
    input  logic              req0,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] len0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] base1,
    input  logic [ADDR_W-1:0] len1,
    output logic              grant0,
    output logic              grant1,
    output logic              done0,
    output logic              done1,
    uart_tx_sched_if.master   bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        LATCH     = 3'd2,
        TRIG      = 3'd3,
        WAIT_BUSY = 3'd4,
        WAIT_IDLE = 3'd5,
        DONE      = 3'd6
    } state_t;

    state_t            state_r, state_s;
    logic              pend0_r, pend1_r;
    logic [ADDR_W-1:0] sbase0_r, slen0_r, sbase1_r, slen1_r;
    logic              last_r, last_s;
    logic              cur_r, cur_s;
    logic              win_s, take0_s, take1_s;
    logic [ADDR_W-1:0] ptr_r, ptr_s;
    logic [ADDR_W-1:0] cnt_r, cnt_s;
    logic [ADDR_W-1:0] len_r, len_s;
    logic [DATA_W-1:0] tx_data_r;
    logic              grant0_r, grant1_r, done0_r, done1_r, rd_en_r, trig_r;
    logic              grant0_s, grant1_s, done0_s, done1_s, rd_en_s, trig_s;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_s = state_r;
        cur_s   = cur_r;
        last_s  = last_r;
        ptr_s   = ptr_r;
        cnt_s   = cnt_r;
        len_s   = len_r;
        take0_s = 1'b0;
        take1_s = 1'b0;
        // Round robin: with both pending, the one not served last wins.
        if (pend0_r && pend1_r) begin
            win_s = ~last_r;
        end else if (pend1_r) begin
            win_s = 1'b1;
        end else begin
            win_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                if (pend0_r || pend1_r) begin
                    cur_s   = win_s;
                    take0_s = ~win_s;
                    take1_s = win_s;
                    ptr_s   = win_s ? sbase1_r : sbase0_r;
                    len_s   = win_s ? slen1_r : slen0_r;
                    cnt_s   = {ADDR_W{1'b0}};
                    state_s = (len_s == {ADDR_W{1'b0}}) ? DONE : READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ:  state_s = LATCH;
            LATCH: state_s = TRIG;
            TRIG:  state_s = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_s = WAIT_IDLE;
                end else begin
                    state_s = WAIT_BUSY;
                end
            end
            WAIT_IDLE: begin
                if (!bus.tx_busy) begin
                    cnt_s   = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    ptr_s   = ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    state_s = (cnt_s == len_r) ? DONE : READ;
                end else begin
                    state_s = WAIT_IDLE;
                end
            end
            DONE: begin
                last_s  = cur_r;
                state_s = IDLE;
            end
            default: state_s = IDLE;
        endcase
        grant0_s = (state_s != IDLE) && !cur_s;
        grant1_s = (state_s != IDLE) && cur_s;
        done0_s  = (state_s == DONE) && !cur_s;
        done1_s  = (state_s == DONE) && cur_s;
        rd_en_s  = (state_s == READ);
        trig_s   = (state_s == TRIG);
    end

    // Pending flags and shadow registers; a new request beats the clear from arbitration.
    always_ff @(posedge sclk) begin
        if (srst) begin
            pend0_r  <= 1'b0;
            pend1_r  <= 1'b0;
            sbase0_r <= {ADDR_W{1'b0}};
            slen0_r  <= {ADDR_W{1'b0}};
            sbase1_r <= {ADDR_W{1'b0}};
            slen1_r  <= {ADDR_W{1'b0}};
        end else begin
            if (req0) begin
                pend0_r  <= 1'b1;
                sbase0_r <= base0;
                slen0_r  <= len0;
            end else if (take0_s) begin
                pend0_r <= 1'b0;
            end
            if (req1) begin
                pend1_r  <= 1'b1;
                sbase1_r <= base1;
                slen1_r  <= len1;
            end else if (take1_s) begin
                pend1_r <= 1'b0;
            end
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge sclk) begin
        if (srst) begin
            state_r   <= IDLE;
            last_r    <= 1'b1;
            cur_r     <= 1'b0;
            ptr_r     <= {ADDR_W{1'b0}};
            cnt_r     <= {ADDR_W{1'b0}};
            len_r     <= {ADDR_W{1'b0}};
            tx_data_r <= {DATA_W{1'b0}};
            grant0_r  <= 1'b0;
            grant1_r  <= 1'b0;
            done0_r   <= 1'b0;
            done1_r   <= 1'b0;
            rd_en_r   <= 1'b0;
            trig_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            last_r   <= last_s;
            cur_r    <= cur_s;
            ptr_r    <= ptr_s;
            cnt_r    <= cnt_s;
            len_r    <= len_s;
            grant0_r <= grant0_s;
            grant1_r <= grant1_s;
            done0_r  <= done0_s;
            done1_r  <= done1_s;
            rd_en_r  <= rd_en_s;
            trig_r   <= trig_s;
            if (state_r == LATCH) begin
                tx_data_r <= bus.ram_rdata;
            end
        end
    end

    assign grant0        = grant0_r;
    assign grant1        = grant1_r;
    assign done0         = done0_r;
    assign done1         = done1_r;
    assign bus.ram_addr  = ptr_r;
    assign bus.ram_rd_en = rd_en_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_trig   = trig_r;

endmodule
